prog_ctr_fetch: RTL
===================

Name: prog_ctr_fetch

Overview:
- Program-counter and fetch-control stage that sits directly upstream of the ALU.
- Generates the instruction address each cycle and consumes the ALU's doBranch.
- Resolves branch targets two ways:
  - PC-relative (BEQ/B).
  - Through a programmable branch-target lookup table (B_LOOKUP).
- Owns the Start/Done run handshake for the processor.

Parameters:
- PC_W, 10, program-counter width in bits (instruction ROM depth 2^PC_W).
- LUT_IDX_W, 4, lookup-table index width (table depth 2^LUT_IDX_W).
- START_ADDR, 0, PC value loaded on reset and on each Start.

Ports:
- Clk, input, 1, single clock; all state updates on rising edge.
- Reset, input, 1, synchronous, active-low; overrides every other input.
- Start, input, 1, run request from testbench/host.
- halt_req, input, 1, decoded halt instruction in the current fetch slot.
- doBranch, input, 1, branch-taken flag from the ALU for the current instruction.
- br_lookup, input, 1, 1 = target comes from the LUT; 0 = PC-relative.
- br_offset, input, 8, signed two's-complement PC-relative offset.
- lut_idx, input, LUT_IDX_W, LUT read index for B_LOOKUP.
- lut_we, input, 1, LUT write enable.
- lut_waddr, input, LUT_IDX_W, LUT write index.
- lut_wdata, input, PC_W, LUT write data (absolute target).
- prog_ctr, output, PC_W, current instruction address to the instruction ROM.
- fetch_valid, output, 1, prog_ctr addresses a live instruction this cycle.
- Done, output, 1, program has halted.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - state=IDLE, prog_ctr=START_ADDR, fetch_valid=0, Done=0.
  - All LUT entries cleared to 0.
  - Reset applied mid-RUN aborts on that edge; no PC update or LUT write occurs.
- State machine, evaluated every edge:
  - IDLE: Start=1 -> LOAD; else stay. prog_ctr held.
  - LOAD: prog_ctr=START_ADDR, Done=0 while Start=1. Start=0 -> RUN.
  - RUN: fetch_valid=1. Priority per edge:
    - (1) halt_req=1 -> HALT, prog_ctr unchanged.
    - (2) doBranch=1 and br_lookup=1 -> prog_ctr = LUT[lut_idx].
    - (3) doBranch=1 and br_lookup=0 -> prog_ctr = prog_ctr + sign_extend(br_offset), modulo 2^PC_W.
    - (4) otherwise prog_ctr = prog_ctr + 1, modulo 2^PC_W (max value wraps to 0).
  - HALT: Done=1, fetch_valid=0, prog_ctr held. Start=1 -> LOAD (Done clears on that edge).
- fetch_valid=0 in IDLE, LOAD and HALT.
- doBranch, halt_req and br_* are ignored outside RUN.
- Registered outputs; single-cycle next-PC latency: inputs sampled at edge N determine prog_ctr after edge N.
- LUT:
  - Written on any edge with lut_we=1, in any state except reset.
  - A same-cycle write and branch read of the same index returns the OLD entry; the new value is visible from the next edge.
- Simultaneous halt_req and doBranch: halt wins; PC is not redirected.
- A branch offset of 0 yields a self-loop (prog_ctr unchanged); this is legal.

Decomposition:
- fetch_pkg holds:
  - typedef enum logic[1:0] {IDLE, LOAD, RUN, HALT} fetch_state_t.
  - Default PC_W, LUT_IDX_W and START_ADDR constants, shared with the instruction ROM and top level.
- One sub-module, branch_lut:
  - 2^LUT_IDX_W x PC_W register array.
  - One synchronous write port, one combinational read port.
  - Synchronous active-low clear.
- Next-PC mux and FSM stay in prog_ctr_fetch.

Test Plan:
- Reset/run: Reset=0 for 2 cycles, Start=1 for 2 cycles, then 0 -> prog_ctr=0, then 1, 2, 3 on successive edges; fetch_valid=1 and Done=0 throughout.
- Relative branch: at prog_ctr=20, doBranch=1, br_lookup=0, br_offset=8'hF6 (-10) -> prog_ctr=10. At prog_ctr=1020, br_offset=+8 -> prog_ctr=4 (wrap).
- Lookup branch: write LUT[3]=700. Later, at prog_ctr=50 with doBranch=1, br_lookup=1, lut_idx=3 -> prog_ctr=700. Same-cycle write LUT[3]=900 with the read -> 700, next lookup -> 900.
- Halt priority: at prog_ctr=15, halt_req=1 and doBranch=1 -> prog_ctr stays 15, Done=1, fetch_valid=0. Subsequent doBranch pulses have no effect.
- Restart: from HALT, Start=1 -> Done=0 and prog_ctr=0 next edge; Start=0 -> counting resumes from 0.
- Reset mid-run: at prog_ctr=123 with lut_we=1, Reset=0 -> prog_ctr=0, state IDLE, Done=0, LUT entry reads 0 (write suppressed).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: the FSM state encoding and default
// geometry constants (also used by the instruction ROM and the top level).
package fetch_pkg;

  localparam int PC_W_DEF       = 10;
  localparam int LUT_IDX_W_DEF  = 4;
  localparam int START_ADDR_DEF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch-target lookup table: one synchronous write port, one combinational
// read port, synchronous active-low clear of every entry.
module branch_lut #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Combinational read: a same-edge write is not visible until after the edge.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_ctr_fetch.sv
// Program counter and fetch control: IDLE/LOAD/RUN/HALT run handshake,
// PC-relative and table-driven branch resolution, halt handling.
module prog_ctr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int LUT_IDX_W  = LUT_IDX_W_DEF,
  parameter int START_ADDR = START_ADDR_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 halt_req,
  input  logic                 doBranch,
  input  logic                 br_lookup,
  input  logic [7:0]           br_offset,
  input  logic [LUT_IDX_W-1:0] lut_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      prog_ctr,
  output logic                 fetch_valid,
  output logic                 Done
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_lut_target;
  logic [PC_W-1:0] w_rel_target;

  branch_lut #(
    .IDX_W  (LUT_IDX_W),
    .DATA_W (PC_W)
  ) u_branch_lut (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_we    (lut_we),
    .i_waddr (lut_waddr),
    .i_wdata (lut_wdata),
    .i_raddr (lut_idx),
    .o_rdata (w_lut_target)
  );

  // Offset is sign-extended to PC width; the add wraps modulo 2^PC_W.
  assign w_rel_target = r_pc + {{(PC_W-8){br_offset[7]}}, br_offset};

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_pc    <= START_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_state_next = LOAD;
          w_pc_next    = START_PC;
        end
      end
      LOAD: begin
        w_pc_next = START_PC;
        if (!Start) w_state_next = RUN;
      end
      RUN: begin
        // Halt outranks any branch in the same slot.
        if (halt_req)                   w_state_next = HALT;
        else if (doBranch && br_lookup) w_pc_next    = w_lut_target;
        else if (doBranch)              w_pc_next    = w_rel_target;
        else                            w_pc_next    = r_pc + 1'b1;
      end
      HALT: begin
        if (Start) begin
          w_state_next = LOAD;
          w_pc_next    = START_PC;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_pc_next    = START_PC;
      end
    endcase
  end

  always_comb begin
    prog_ctr    = r_pc;
    fetch_valid = (r_state == RUN);
    Done        = (r_state == HALT);
  end

endmodule
